// File: rtl/i2s_mic_rx_stereo_if.sv
// Sample-side bus of the stereo I2S microphone receiver.
//   sample_l / sample_r : signed sample pair, two's complement
//   sample_valid        : a pair is held and has not been accepted yet
//   sample_ready        : the consumer accepts the pair on this clock
//   overrun             : sticky, a new frame replaced an unaccepted pair
//   dac_l / dac_r       : offset-binary top bits of the pair for the resistor DAC
// master = receiver side, slave = consumer side.
interface i2s_mic_rx_stereo_if #(
  parameter int SAMPLE_BITS = 24,
  parameter int OUT_BITS    = 4
);
  logic signed [SAMPLE_BITS-1:0] sample_l;
  logic signed [SAMPLE_BITS-1:0] sample_r;
  logic                          sample_valid;
  logic                          sample_ready;
  logic                          overrun;
  logic [OUT_BITS-1:0]           dac_l;
  logic [OUT_BITS-1:0]           dac_r;

  modport master (
    output sample_l, sample_r, sample_valid, overrun, dac_l, dac_r,
    input  sample_ready
  );

  modport slave (
    input  sample_l, sample_r, sample_valid, overrun, dac_l, dac_r,
    output sample_ready
  );
endinterface

// File: rtl/i2s_mic_rx_stereo.sv
// I2S master receiver for one or two MEMS microphones sharing one data line.
// Generates the bit clock and word select from clk_25mhz, deserialises the
// left and right slots into signed samples and hands each pair out with a
// valid/ready handshake. The same pair also drives a small offset-binary DAC.
//
// Ports:
//   clk_25mhz  : sole clock
//   reset      : asynchronous, active-high
//   enable     : run request, sampled only in IDLE and at frame boundaries
//   ultrasonic : 0 = DIV_STD, 1 = DIV_US, latched at frame boundaries
//   mic_data   : serial data from the microphone(s)
//   mic_bclk   : bit clock out
//   mic_ws     : word select out, 0 = left, 1 = right
//   smp        : sample bus (pair, valid/ready, overrun, DAC codes)
module i2s_mic_rx_stereo #(
  parameter int DIV_STD     = 6,
  parameter int DIV_US      = 3,
  parameter int SLOT_BITS   = 32,
  parameter int SAMPLE_BITS = 24,
  parameter int OUT_BITS    = 4
) (
  input  logic clk_25mhz,
  input  logic reset,
  input  logic enable,
  input  logic ultrasonic,
  input  logic mic_data,
  output logic mic_bclk,
  output logic mic_ws,
  i2s_mic_rx_stereo_if.master smp
);

  localparam int FRAME   = 2 * SLOT_BITS;
  localparam int P_W     = $clog2(FRAME);
  localparam int DIV_MAX = (DIV_STD > DIV_US) ? DIV_STD : DIV_US;
  localparam int CNT_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

  localparam logic [CNT_W-1:0] STD_LAST = CNT_W'(DIV_STD - 1);
  localparam logic [CNT_W-1:0] US_LAST  = CNT_W'(DIV_US - 1);

  localparam logic [P_W-1:0] P_LAST   = P_W'(FRAME - 1);
  localparam logic [P_W-1:0] WS_FIRST = P_W'(SLOT_BITS - 1);
  localparam logic [P_W-1:0] WS_LAST  = P_W'(FRAME - 2);
  localparam logic [P_W-1:0] L_FIRST  = P_W'(1);
  localparam logic [P_W-1:0] L_LAST   = P_W'(SAMPLE_BITS);
  localparam logic [P_W-1:0] R_FIRST  = P_W'(SLOT_BITS + 1);
  localparam logic [P_W-1:0] R_LAST   = P_W'(SLOT_BITS + SAMPLE_BITS);

  localparam logic [OUT_BITS-1:0] DAC_MSB = OUT_BITS'(1 << (OUT_BITS - 1));

  typedef enum logic {IDLE, RUN} state_t;

  // Offset-binary DAC code: keep the top OUT_BITS of the sample and flip the
  // sign bit so that zero maps to midscale.
  function automatic logic [OUT_BITS-1:0] dac_code(input logic signed [SAMPLE_BITS-1:0] s);
    logic [OUT_BITS-1:0] top;
    top = s[SAMPLE_BITS-1 -: OUT_BITS];
    return top ^ DAC_MSB;
  endfunction

  state_t                        state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          bclk_q, bclk_d;
  logic                          ws_q, ws_d;
  logic [P_W-1:0]                p_q, p_d;
  logic                          us_q, us_d;
  logic signed [SAMPLE_BITS-1:0] shl_q, shl_d;
  logic signed [SAMPLE_BITS-1:0] shr_q, shr_d;
  logic signed [SAMPLE_BITS-1:0] sl_q, sl_d;
  logic signed [SAMPLE_BITS-1:0] sr_q, sr_d;
  logic                          vld_q, vld_d;
  logic                          ovr_q, ovr_d;
  logic [OUT_BITS-1:0]           dacl_q, dacl_d;
  logic [OUT_BITS-1:0]           dacr_q, dacr_d;

  logic [CNT_W-1:0] div_last;
  logic [P_W-1:0]   p_nxt;
  logic             rise;
  logic             fall;
  logic             publish;

  assign div_last = us_q ? US_LAST : STD_LAST;

  // Timing FSM: divider, bclk/ws generation, bit position, mode and run control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bclk_d  = bclk_q;
    ws_d    = ws_q;
    p_d     = p_q;
    us_d    = us_q;
    p_nxt   = '0;
    rise    = 1'b0;
    fall    = 1'b0;
    publish = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        bclk_d = 1'b0;
        ws_d   = 1'b0;
        p_d    = '0;
        if (enable) begin
          state_d = RUN;
          us_d    = ultrasonic;
        end
      end
      RUN: begin
        if (cnt_q == div_last) begin
          cnt_d  = '0;
          bclk_d = ~bclk_q;
          rise   = ~bclk_q;
          fall   = bclk_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if (fall) begin
          p_nxt = (p_q == P_LAST) ? '0 : p_q + 1'b1;
          p_d   = p_nxt;
          // WS leads the slot by one bit, so it switches at the last bit of
          // the previous slot.
          ws_d  = (p_nxt >= WS_FIRST) && (p_nxt <= WS_LAST);
          if (p_q == P_LAST) begin
            // Frame boundary: hand out the pair, re-read the rate and honour
            // a pending stop request.
            publish = 1'b1;
            us_d    = ultrasonic;
            if (!enable) begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture, publish and handshake.
  always_comb begin
    shl_d  = shl_q;
    shr_d  = shr_q;
    sl_d   = sl_q;
    sr_d   = sr_q;
    dacl_d = dacl_q;
    dacr_d = dacr_q;
    vld_d  = vld_q;
    ovr_d  = ovr_q;
    if (rise && (p_q >= L_FIRST) && (p_q <= L_LAST)) begin
      shl_d = {shl_q[SAMPLE_BITS-2:0], mic_data};
    end
    if (rise && (p_q >= R_FIRST) && (p_q <= R_LAST)) begin
      shr_d = {shr_q[SAMPLE_BITS-2:0], mic_data};
    end
    if (vld_q && smp.sample_ready) begin
      vld_d = 1'b0;
    end
    if (publish) begin
      sl_d   = shl_q;
      sr_d   = shr_q;
      dacl_d = dac_code(shl_q);
      dacr_d = dac_code(shr_q);
      vld_d  = 1'b1;
      if (vld_q && !smp.sample_ready) begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bclk_q  <= 1'b0;
      ws_q    <= 1'b0;
      p_q     <= '0;
      us_q    <= 1'b0;
      sl_q    <= '0;
      sr_q    <= '0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
      dacl_q  <= DAC_MSB;
      dacr_q  <= DAC_MSB;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bclk_q  <= bclk_d;
      ws_q    <= ws_d;
      p_q     <= p_d;
      us_q    <= us_d;
      sl_q    <= sl_d;
      sr_q    <= sr_d;
      vld_q   <= vld_d;
      ovr_q   <= ovr_d;
      dacl_q  <= dacl_d;
      dacr_q  <= dacr_d;
    end
  end

  // Shift registers are fully rewritten every frame before they are published,
  // so they carry no reset.
  always_ff @(posedge clk_25mhz) begin
    shl_q <= shl_d;
    shr_q <= shr_d;
  end

  assign mic_bclk         = bclk_q;
  assign mic_ws           = ws_q;
  assign smp.sample_l     = sl_q;
  assign smp.sample_r     = sr_q;
  assign smp.sample_valid = vld_q;
  assign smp.overrun      = ovr_q;
  assign smp.dac_l        = dacl_q;
  assign smp.dac_r        = dacr_q;

endmodule

// File: tb/tb_i2s_mic_rx_stereo.sv
// Bench for i2s_mic_rx_stereo: a default 24/4 build and a 16/8 build run side
// by side from the same control inputs, each with its own microphone model.
module tb_i2s_mic_rx_stereo;
  localparam int DSTD  = 6;
  localparam int DUS   = 3;
  localparam int SLOT  = 32;
  localparam int FRAME = 2 * SLOT;
  localparam int SB    = 24;
  localparam int OB    = 4;
  localparam int SB2   = 16;
  localparam int OB2   = 8;

  logic clk = 1'b0;
  logic rst, enable, ultrasonic, ready;
  logic mic_data, mic_data2;
  logic bclk, ws, bclk2, ws2;

  always #20 clk = ~clk;

  i2s_mic_rx_stereo_if #(.SAMPLE_BITS(SB),  .OUT_BITS(OB))  bus ();
  i2s_mic_rx_stereo_if #(.SAMPLE_BITS(SB2), .OUT_BITS(OB2)) bus2 ();

  assign bus.sample_ready  = ready;
  assign bus2.sample_ready = ready;

  i2s_mic_rx_stereo #(.DIV_STD(DSTD), .DIV_US(DUS), .SLOT_BITS(SLOT),
                      .SAMPLE_BITS(SB), .OUT_BITS(OB)) dut (
    .clk_25mhz(clk), .reset(rst), .enable(enable), .ultrasonic(ultrasonic),
    .mic_data(mic_data), .mic_bclk(bclk), .mic_ws(ws), .smp(bus));

  i2s_mic_rx_stereo #(.DIV_STD(DSTD), .DIV_US(DUS), .SLOT_BITS(SLOT),
                      .SAMPLE_BITS(SB2), .OUT_BITS(OB2)) dut2 (
    .clk_25mhz(clk), .reset(rst), .enable(enable), .ultrasonic(ultrasonic),
    .mic_data(mic_data2), .mic_bclk(bclk2), .mic_ws(ws2), .smp(bus2));

  int nvec = 0;
  int nerr = 0;

  // Reference model state.
  bit m_run, exp_bclk, exp_ws, exp_vld, exp_ovr, pub, use_dir;
  int m_div, cyc, pos, n_pub;
  logic [SB-1:0]  cur_l, cur_r, exp_l, exp_r;
  logic [SB2-1:0] cur_l2, cur_r2, exp_l2, exp_r2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Offset binary: top bits read as a signed value plus half scale.
  function automatic logic [OB-1:0] dac1(input logic [SB-1:0] s);
    return OB'((s >> (SB - OB)) + (1 << (OB - 1)));
  endfunction

  function automatic logic [OB2-1:0] dac2(input logic [SB2-1:0] s);
    return OB2'((s >> (SB2 - OB2)) + (1 << (OB2 - 1)));
  endfunction

  // Microphone: MSB one bit after the slot starts, junk elsewhere.
  function automatic logic mic1(input int p, input logic [SB-1:0] l, input logic [SB-1:0] r);
    logic [SB-1:0] t;
    if (p >= 1 && p <= SB) begin
      t = l >> (SB - p);
      return t[0];
    end
    if (p >= SLOT + 1 && p <= SLOT + SB) begin
      t = r >> (SLOT + SB - p);
      return t[0];
    end
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic mic2(input int p, input logic [SB2-1:0] l, input logic [SB2-1:0] r);
    logic [SB2-1:0] t;
    if (p >= 1 && p <= SB2) begin
      t = l >> (SB2 - p);
      return t[0];
    end
    if (p >= SLOT + 1 && p <= SLOT + SB2) begin
      t = r >> (SLOT + SB2 - p);
      return t[0];
    end
    return 1'b1;
  endfunction

  task automatic new_words();
    cur_l  = use_dir ? 24'h800001 : SB'($urandom);
    cur_r  = use_dir ? 24'h7FFFFF : SB'($urandom);
    cur_l2 = 16'h1234;
    cur_r2 = SB2'($urandom);
  endtask

  // Model + compare, once per clock just after the active edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        m_run = 0; exp_bclk = 0; cyc = 0; pos = 0; m_div = DSTD;
        exp_vld = 0; exp_ovr = 0;
        exp_l = '0; exp_r = '0; exp_l2 = '0; exp_r2 = '0;
        new_words();
        mic_data = 1'b0; mic_data2 = 1'b0;
      end else begin
        pub = 0;
        if (!m_run) begin
          if (enable) begin
            m_run = 1;
            m_div = ultrasonic ? DUS : DSTD;
            cyc = 0;
          end
        end else begin
          cyc++;
          if (cyc == m_div) begin
            cyc = 0;
            exp_bclk = ~exp_bclk;
            if (!exp_bclk) begin
              pos = (pos + 1) % FRAME;
              if (pos == 0) begin
                pub = 1;
                m_div = ultrasonic ? DUS : DSTD;
                if (!enable) m_run = 0;
              end
            end
          end
        end
        if (pub) begin
          if (exp_vld && !ready) exp_ovr = 1;
          exp_vld = 1;
          exp_l = cur_l; exp_r = cur_r; exp_l2 = cur_l2; exp_r2 = cur_r2;
          n_pub++;
          use_dir = 0;
          new_words();
        end else if (exp_vld && ready) begin
          exp_vld = 0;
        end
        mic_data  = mic1(pos, cur_l, cur_r);
        mic_data2 = mic2(pos, cur_l2, cur_r2);
      end
      exp_ws = (pos >= SLOT - 1) && (pos <= FRAME - 2);
      chk("bclk",     32'(bclk),                  32'(exp_bclk));
      chk("ws",       32'(ws),                    32'(exp_ws));
      chk("valid",    32'(bus.sample_valid),      32'(exp_vld));
      chk("overrun",  32'(bus.overrun),           32'(exp_ovr));
      chk("sample_l", 32'($unsigned(bus.sample_l)), 32'(exp_l));
      chk("sample_r", 32'($unsigned(bus.sample_r)), 32'(exp_r));
      chk("dac_l",    32'(bus.dac_l),             32'(dac1(exp_l)));
      chk("dac_r",    32'(bus.dac_r),             32'(dac1(exp_r)));
      chk("b2_bclk",  32'(bclk2),                 32'(exp_bclk));
      chk("b2_ws",    32'(ws2),                   32'(exp_ws));
      chk("b2_valid", 32'(bus2.sample_valid),     32'(exp_vld));
      chk("b2_l",     32'($unsigned(bus2.sample_l)), 32'(exp_l2));
      chk("b2_r",     32'($unsigned(bus2.sample_r)), 32'(exp_r2));
      chk("b2_dac_l", 32'(bus2.dac_l),            32'(dac2(exp_l2)));
      chk("b2_dac_r", 32'(bus2.dac_r),            32'(dac2(exp_r2)));
    end
  end

  task automatic wait_pub(input int n);
    int target;
    int k;
    target = n_pub + n;
    k = 0;
    while (n_pub < target && k < 4000) begin
      @(negedge clk);
      k++;
    end
    chk("publish_timeout", 32'(n_pub >= target), 32'd1);
  endtask

  task automatic wait_pos(input int p);
    int k;
    k = 0;
    @(negedge clk);
    while (!(m_run && pos == p) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("pos_timeout", 32'(m_run && pos == p), 32'd1);
  endtask

  // Returns at the negedge just before the edge that publishes.
  task automatic wait_prepub();
    int k;
    k = 0;
    @(negedge clk);
    while (!(m_run && pos == FRAME - 1 && exp_bclk && cyc == m_div - 1) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("prepub_timeout", 32'(k < 2000), 32'd1);
  endtask

  initial begin
    int k;
    rst = 1'b1; enable = 1'b0; ultrasonic = 1'b0; ready = 1'b0;
    use_dir = 1; n_pub = 0;
    repeat (3) @(negedge clk);
    chk("rst_dac_l",  32'(bus.dac_l),  32'h8);
    chk("rst_dac_r",  32'(bus.dac_r),  32'h8);
    chk("rst_dac2_l", 32'(bus2.dac_l), 32'h80);
    chk("rst_valid",  32'(bus.sample_valid), 32'd0);
    rst = 1'b0;
    enable = 1'b1;

    // First frame, standard rate, known words.
    wait_pub(1);
    chk("f1_sample_l", 32'($unsigned(bus.sample_l)), 32'h800001);
    chk("f1_sample_r", 32'($unsigned(bus.sample_r)), 32'h7FFFFF);
    chk("f1_dac_l",    32'(bus.dac_l), 32'h0);
    chk("f1_dac_r",    32'(bus.dac_r), 32'hF);
    chk("f1_b2_l",     32'($unsigned(bus2.sample_l)), 32'h1234);
    chk("f1_b2_dac_l", 32'(bus2.dac_l), 32'h92);
    chk("f1_overrun",  32'(bus.overrun), 32'd0);

    // Second frame without ready: overrun.
    wait_pub(1);
    chk("f2_overrun", 32'(bus.overrun), 32'd1);
    chk("f2_valid",   32'(bus.sample_valid), 32'd1);

    // Reset in the middle of a frame.
    wait_pos(20);
    rst = 1'b1;
    #1;
    chk("mid_rst_bclk",  32'(bclk), 32'd0);
    chk("mid_rst_ws",    32'(ws), 32'd0);
    chk("mid_rst_valid", 32'(bus.sample_valid), 32'd0);
    chk("mid_rst_ovr",   32'(bus.overrun), 32'd0);
    chk("mid_rst_dac_l", 32'(bus.dac_l), 32'h8);
    chk("mid_rst_dac_r", 32'(bus.dac_r), 32'h8);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_pub(1);

    // Ready rises exactly on a publish while a pair is still held.
    wait_prepub();
    ready = 1'b1;
    wait_pub(1);
    chk("xfer_pub_valid",   32'(bus.sample_valid), 32'd1);
    chk("xfer_pub_overrun", 32'(bus.overrun), 32'd0);
    ready = 1'b0;

    // Rate change mid-frame only applies from the next frame.
    wait_pos(10);
    ultrasonic = 1'b1;
    wait_pub(2);

    // Random traffic.
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 59) == 0) ready = ~ready;
      if ($urandom_range(0, 499) == 0) ultrasonic = ~ultrasonic;
    end

    // Stop request mid-frame, idle, then restart.
    ready = 1'b1;
    wait_pos(5);
    enable = 1'b0;
    k = 0;
    while (m_run && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("stop_timeout", 32'(m_run), 32'd0);
    repeat (40) @(negedge clk);
    ultrasonic = 1'b0;
    enable = 1'b1;
    k = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (bclk) break;
      k++;
    end
    chk("restart_first_rise", 32'(k), 32'd6);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 59) == 0) ready = ~ready;
      if ($urandom_range(0, 499) == 0) ultrasonic = ~ultrasonic;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/i2s_mic_rx_stereo.md
Name: i2s_mic_rx_stereo

Overview:
- Parametrised I2S master receiver for one or two MEMS microphones sharing a data line, with select pins tied to opposite levels.
- Generates mic_bclk and mic_ws from clk_25mhz with a divider. Two rates are selectable at runtime: standard and ultrasonic.
- Deserialises both channels into signed samples with a valid/ready handshake and overrun flag.
- Also drives truncated offset-binary left/right outputs for the 4-bit resistor audio DAC.

Parameters:
- DIV_STD, 6: clk_25mhz cycles per bclk half-period, standard mode (bclk ≈ 2.08 MHz).
- DIV_US, 3: clk_25mhz cycles per bclk half-period, ultrasonic mode (bclk ≈ 4.17 MHz).
- SLOT_BITS, 32: bclk periods per channel slot. A frame is 2*SLOT_BITS.
- SAMPLE_BITS, 24: bits captured per channel. Must be ≤ SLOT_BITS-1.
- OUT_BITS, 4: DAC output width. Must be ≤ SAMPLE_BITS.

Ports:
- clk_25mhz  in  1  sole clock.
- reset  in  1  asynchronous, active-high.
- enable  in  1  run request.
- ultrasonic  in  1  0 = DIV_STD, 1 = DIV_US.
- mic_data  in  1  serial data from microphone(s).
- mic_bclk  out  1  bit clock.
- mic_ws  out  1  word select: 0 = left, 1 = right.
- sample_l  out  SAMPLE_BITS  left sample, two's complement.
- sample_r  out  SAMPLE_BITS  right sample, two's complement.
- sample_valid  out  1  sample pair available.
- sample_ready  in  1  consumer accepts the pair.
- overrun  out  1  sticky: a frame overwrote an unaccepted pair.
- dac_l  out  OUT_BITS  top OUT_BITS of sample_l, MSB inverted.
- dac_r  out  OUT_BITS  top OUT_BITS of sample_r, MSB inverted.

Behaviour:
- Reset values:
  - mic_bclk=0, mic_ws=0.
  - Divider counter=0, bit position p=0, state IDLE.
  - sample_l/r=0, sample_valid=0, overrun=0.
  - dac_l/r=1000 (midscale for a zero sample).
- Reset asserted mid-frame aborts the frame immediately. No partial sample is published.
- States:
  - IDLE: bclk held low, ws low, p=0. Moves to RUN on the clk after enable=1.
  - RUN: free-running frames.
- Mode latch: active divisor DIV is latched from ultrasonic on entry to RUN and at every frame boundary (p wraps 2*SLOT_BITS-1→0). Mid-frame changes of ultrasonic are ignored until that boundary.
- Divider:
  - Counter runs 0..DIV-1. At DIV-1 mic_bclk toggles and the counter clears.
  - bclk period = 2*DIV clk cycles, 50% duty.
- Falling edge (bclk 1→0):
  - p advances, wrapping at 2*SLOT_BITS.
  - mic_ws is driven 1 for p in [SLOT_BITS-1, 2*SLOT_BITS-2], else 0. This is the standard I2S one-bit WS lead.
- Rising edge (bclk 0→1): mic_data is sampled in the same clk cycle that bclk is driven high.
  - Left shift register captures at p=1..SAMPLE_BITS, MSB first.
  - Right shift register captures at p=SLOT_BITS+1..SLOT_BITS+SAMPLE_BITS.
  - All other bits are ignored.
- Publish at the falling edge where p wraps to 0; the effects below appear on the next clk:
  - sample_l/r load from the shift registers.
  - dac_l/r update: top OUT_BITS with MSB inverted.
  - sample_valid=1.
- Handshake:
  - A transfer occurs on a clk where sample_valid && sample_ready. sample_valid clears on the next clk unless a publish occurs in that same cycle; publish wins and valid stays 1.
  - Publish while sample_valid=1 and no transfer in that cycle: data is overwritten and overrun is set to 1. overrun clears only on reset.
  - dac_l/r update on every publish, independent of ready.
- Enable deassert:
  - Takes effect at the next frame boundary: the final frame is published, then the block enters IDLE.
  - Re-assert while still in RUN has no effect.
  - Re-entry from IDLE starts at p=0 with counter=0.
- First frame after entering RUN is published normally. Data from an absent microphone reads as whatever the line floats to.

Test Plan:
1. Reset mid-frame, p≈20 -> within the same cycle bclk=0, ws=0, sample_valid=0, overrun=0, dac_l=dac_r=1000. After release with enable=1, a full frame is produced.
2. Standard mode, mic model drives left 0x800001 and right 0x7FFFFF -> one frame after start: sample_l=0x800001, sample_r=0x7FFFFF, dac_l=0000, dac_r=1111. bclk period is 12 clks, ws high for 32 bclks starting at p=31.
3. ultrasonic toggled 0→1 at p=10 -> current frame completes at a 12-clk period, next frame runs at a 6-clk period. Samples from both frames are correct.
4. sample_ready held 0 across two frames -> after the 2nd publish overrun=1 and sample_l/r hold frame-2 data. With ready=1 at a publish cycle, sample_valid stays 1 and overrun is unchanged.
5. enable dropped at p=5 -> the frame finishes and is published, then bclk stays low and ws stays 0. enable=1 again -> bclk restarts with first rising edge 6 clks later, p starting at 0.
6. SAMPLE_BITS=16, OUT_BITS=8 build with mic driving 0x1234 left and bits beyond position 16 set to 1 -> sample_l=0x1234 (trailing bits ignored), dac_l=0x92.
